// File: rtl/traffic_pkg.sv
// Shared light encodings, phase enum, fault codes and phase-order helpers
// for the traffic-light monitor family.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    NSG   = 3'd1,
    NSY   = 3'd2,
    EWG   = 3'd3,
    EWY   = 3'd4,
    FAULT = 3'd5
  } phase_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ENC      = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_SEQ      = 3'd3;
  localparam logic [2:0] FC_SHORT    = 3'd4;
  localparam logic [2:0] FC_LONG     = 3'd5;

  function automatic phase_e succ_phase(phase_e p);
    phase_e s;
    s = SYNC;
    unique case (p)
      NSG:     s = NSY;
      NSY:     s = EWG;
      EWG:     s = EWY;
      EWY:     s = NSG;
      default: s = SYNC;
    endcase
    return s;
  endfunction

  function automatic logic is_green(phase_e p);
    return (p == NSG) || (p == EWG);
  endfunction

endpackage

// File: rtl/light_pair_decode.sv
// Combinational decode of a registered NS/EW light pair into a phase,
// an encoding error flag and a conflict flag.
module light_pair_decode
  import traffic_pkg::*;
(
  input  logic [2:0] ns_i,
  input  logic [2:0] ew_i,
  output phase_e     phase_o,
  output logic       enc_err_o,
  output logic       conflict_o
);

  logic       ns_oh;
  logic       ew_oh;
  logic [5:0] pair;

  assign ns_oh = $onehot(ns_i);
  assign ew_oh = $onehot(ew_i);
  assign pair  = {ns_i, ew_i};

  always_comb begin
    phase_o    = SYNC;
    enc_err_o  = 1'b0;
    conflict_o = 1'b0;
    unique case (1'b1)
      !(ns_oh && ew_oh):        enc_err_o = 1'b1;
      pair == {LT_GRN, LT_RED}: phase_o   = NSG;
      pair == {LT_YEL, LT_RED}: phase_o   = NSY;
      pair == {LT_RED, LT_GRN}: phase_o   = EWG;
      pair == {LT_RED, LT_YEL}: phase_o   = EWY;
      default:                  conflict_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor for the controller's light outputs with sticky fault code
// and safe lamp drive. TRAFFIC_MON_FLASH_EN enables red flashing in FAULT.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = 10,
  parameter int GREEN_MAX  = 12,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 4,
  parameter int FLASH_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] NS_light,
  input  logic [2:0] EW_light,
  input  logic       clr,
  output logic [2:0] phase,
  output logic [7:0] dwell,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] safe_NS_light,
  output logic [2:0] safe_EW_light
);

  logic [2:0] ns_q, ew_q;
  phase_e     st_q, st_d;
  phase_e     dec_phase;
  logic       enc_err, conflict;
  logic [7:0] dwell_q, dwell_d;
  logic       first_q, first_d;
  logic [2:0] code_q, code_d;
  logic [2:0] sns_q, sns_d;
  logic [2:0] sew_q, sew_d;
  logic [7:0] min_c, max_c;
  logic [2:0] flash_lt;

  light_pair_decode u_dec (
    .ns_i       (ns_q),
    .ew_i       (ew_q),
    .phase_o    (dec_phase),
    .enc_err_o  (enc_err),
    .conflict_o (conflict)
  );

  always_comb begin
    min_c = is_green(st_q) ? 8'(GREEN_MIN) : 8'(YELLOW_MIN);
    max_c = is_green(st_q) ? 8'(GREEN_MAX) : 8'(YELLOW_MAX);
  end

  always_comb begin
    st_d    = st_q;
    dwell_d = dwell_q;
    first_d = first_q;
    code_d  = code_q;
    priority case (1'b1)
      clr: begin
        st_d    = SYNC;
        dwell_d = '0;
        first_d = 1'b0;
        code_d  = FC_NONE;
      end
      st_q == FAULT: begin
      end
      st_q == SYNC: begin
        if (dec_phase != SYNC) begin
          st_d    = dec_phase;
          dwell_d = 8'd1;
          first_d = 1'b1;
        end
      end
      enc_err: begin
        st_d   = FAULT;
        code_d = FC_ENC;
      end
      conflict: begin
        st_d   = FAULT;
        code_d = FC_CONFLICT;
      end
      dec_phase == st_q: begin
        if (dwell_q == max_c) begin
          st_d   = FAULT;
          code_d = FC_LONG;
        end else if (dwell_q != 8'hFF) begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      dec_phase == succ_phase(st_q): begin
        // the phase caught on leaving SYNC may be partial
        if (!first_q && (dwell_q < min_c)) begin
          st_d   = FAULT;
          code_d = FC_SHORT;
        end else begin
          st_d    = dec_phase;
          dwell_d = 8'd1;
          first_d = 1'b0;
        end
      end
      default: begin
        st_d   = FAULT;
        code_d = FC_SEQ;
      end
    endcase
  end

`ifdef TRAFFIC_MON_FLASH_EN
  localparam int FW = $clog2(FLASH_CYC + 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fon_q, fon_d;

  always_comb begin
    fcnt_d = fcnt_q;
    fon_d  = fon_q;
    if ((st_d == FAULT) && (st_q != FAULT)) begin
      fcnt_d = '0;
      fon_d  = 1'b1;
    end else if (st_q == FAULT) begin
      if (fcnt_q == FW'(FLASH_CYC - 1)) begin
        fcnt_d = '0;
        fon_d  = !fon_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q <= '0;
      fon_q  <= 1'b1;
    end else begin
      fcnt_q <= fcnt_d;
      fon_q  <= fon_d;
    end
  end

  assign flash_lt = fon_d ? LT_RED : 3'b000;
`else
  assign flash_lt = LT_RED;
`endif

  always_comb begin
    sns_d = LT_RED;
    sew_d = LT_RED;
    if (st_d == FAULT) begin
      sns_d = flash_lt;
      sew_d = flash_lt;
    end else if (st_d != SYNC) begin
      sns_d = ns_q;
      sew_d = ew_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ns_q    <= LT_RED;
      ew_q    <= LT_RED;
      st_q    <= SYNC;
      dwell_q <= '0;
      first_q <= 1'b0;
      code_q  <= FC_NONE;
      sns_q   <= LT_RED;
      sew_q   <= LT_RED;
    end else begin
      ns_q    <= NS_light;
      ew_q    <= EW_light;
      st_q    <= st_d;
      dwell_q <= dwell_d;
      first_q <= first_d;
      code_q  <= code_d;
      sns_q   <= sns_d;
      sew_q   <= sew_d;
    end
  end

  assign phase         = st_q;
  assign dwell         = dwell_q;
  assign fault         = (st_q == FAULT);
  assign fault_code    = code_q;
  assign safe_NS_light = sns_q;
  assign safe_EW_light = sew_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized bench for traffic_light_monitor against a phase-run model.
// Define TRAFFIC_MON_FLASH_EN here too when building the flash variant.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] NS_light = R;
  logic [2:0] EW_light = R;
  logic [2:0] phase;
  logic [7:0] dwell;
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] safe_NS_light;
  logic [2:0] safe_EW_light;

  traffic_light_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .NS_light      (NS_light),
    .EW_light      (EW_light),
    .clr           (clr),
    .phase         (phase),
    .dwell         (dwell),
    .fault         (fault),
    .fault_code    (fault_code),
    .safe_NS_light (safe_NS_light),
    .safe_EW_light (safe_EW_light)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: 0 = sync, 1..4 = NSG,NSY,EWG,EWY in ring order, 5 = fault.
  int         m_state;
  int         m_run;
  bit         m_partial;
  int         m_code;
  int         m_age;
  logic [2:0] m_ns, m_ew;
  logic [2:0] m_sns, m_sew;

  function automatic logic [2:0] lt_ns(int p);
    return (p == 1) ? G : (p == 2) ? Y : R;
  endfunction

  function automatic logic [2:0] lt_ew(int p);
    return (p == 3) ? G : (p == 4) ? Y : R;
  endfunction

  function automatic int classify(logic [2:0] ns, logic [2:0] ew);
    if ($countones(ns) != 1 || $countones(ew) != 1) return -1;
    for (int p = 1; p <= 4; p++)
      if (ns == lt_ns(p) && ew == lt_ew(p)) return p;
    return -2;
  endfunction

  function automatic int lo_lim(int p);
    return (p % 2 == 1) ? 10 : 2;
  endfunction

  function automatic int hi_lim(int p);
    return (p % 2 == 1) ? 12 : 4;
  endfunction

  task automatic m_reset();
    m_state = 0; m_run = 0; m_partial = 0; m_code = 0; m_age = 0;
    m_ns = R; m_ew = R; m_sns = R; m_sew = R;
  endtask

  task automatic trip(int code);
    m_state = 5; m_code = code; m_age = 0;
  endtask

  task automatic m_step(logic [2:0] ns, logic [2:0] ew, bit c);
    int k;
    k = classify(m_ns, m_ew);
    if (c) begin
      m_state = 0; m_run = 0; m_code = 0;
    end else if (m_state == 5) begin
      m_age++;
    end else if (m_state == 0) begin
      if (k > 0) begin
        m_state = k; m_run = 1; m_partial = 1;
      end
    end else if (k == -1) trip(1);
    else if (k == -2) trip(2);
    else if (k == m_state) begin
      if (m_run + 1 > hi_lim(m_state)) trip(5);
      else m_run++;
    end else if (k == m_state % 4 + 1) begin
      if (!m_partial && m_run < lo_lim(m_state)) trip(4);
      else begin
        m_state = k; m_run = 1; m_partial = 0;
      end
    end else trip(3);

    if (m_state >= 1 && m_state <= 4) begin
      m_sns = m_ns; m_sew = m_ew;
    end else if (m_state == 5) begin
`ifdef TRAFFIC_MON_FLASH_EN
      m_sns = ((m_age / 4) % 2 == 0) ? R : 3'b000;
`else
      m_sns = R;
`endif
      m_sew = m_sns;
    end else begin
      m_sns = R; m_sew = R;
    end
    m_ns = ns; m_ew = ew;
  endtask

  task automatic cmp_all();
    chk("phase", 32'(phase), 32'(m_state));
    chk("fault", 32'(fault), 32'(m_state == 5));
    chk("code", 32'(fault_code), 32'(m_code));
    chk("safe_ns", 32'(safe_NS_light), 32'(m_sns));
    chk("safe_ew", 32'(safe_EW_light), 32'(m_sew));
    if (m_state != 5) chk("dwell", 32'(dwell), 32'(m_run));
  endtask

  task automatic cyc(logic [2:0] ns, logic [2:0] ew, bit c = 1'b0);
    NS_light = ns; EW_light = ew; clr = c;
    @(posedge clk);
    m_step(ns, ew, c);
    @(negedge clk);
    cmp_all();
    clr = 1'b0;
  endtask

  task automatic hold(int p, int n);
    repeat (n) cyc(lt_ns(p), lt_ew(p));
  endtask

  task automatic async_reset(string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_dwell"}, 32'(dwell), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_code"}, 32'(fault_code), 0);
    chk({tag, "_sns"}, 32'(safe_NS_light), 32'(R));
    chk({tag, "_sew"}, 32'(safe_EW_light), 32'(R));
    m_reset();
    #1;
    rst = 1'b1;
  endtask

  function automatic int pick_len(int p);
    if ($urandom_range(0, 9) == 0)
      return (p % 2 == 1) ? $urandom_range(7, 14) : $urandom_range(1, 5);
    return (p % 2 == 1) ? $urandom_range(10, 12) : $urandom_range(2, 4);
  endfunction

  initial begin
    int gp;
    int r;
    m_reset();
    repeat (2) @(negedge clk);
    async_reset("rst0");

    for (int i = 0; i < 3; i++) begin
      hold(1, 10); hold(2, 2); hold(3, 10); hold(4, 2);
    end
    chk("legal_fault", 32'(fault), 0);

    hold(1, 5);
    cyc(3'b011, R);
    hold(1, 3);
    chk("enc_code", 32'(fault_code), 1);
    chk("enc_sns", 32'(safe_NS_light), 32'(R));
    cyc(R, R, 1'b1);

    hold(1, 3); cyc(G, G); cyc(R, R);
    chk("conf_gg", 32'(fault_code), 2);
    cyc(R, R, 1'b1);
    hold(3, 3); cyc(R, R); cyc(R, R);
    chk("conf_rr", 32'(fault_code), 2);
    cyc(R, R, 1'b1);

    hold(1, 3); hold(3, 2);
    chk("seq_code", 32'(fault_code), 3);
    cyc(R, R, 1'b1);

    hold(1, 2); hold(2, 2); hold(3, 9); hold(4, 2);
    chk("short_code", 32'(fault_code), 4);
    cyc(R, R, 1'b1);

    hold(3, 3); hold(4, 2); hold(1, 14);
    chk("long_code", 32'(fault_code), 5);
    cyc(R, R, 1'b1);

    hold(1, 3); cyc(G, G); cyc(R, R, 1'b1);
    chk("clrwin_fault", 32'(fault), 0);
    chk("clrwin_phase", 32'(phase), 0);

    hold(1, 3); hold(2, 2); hold(3, 1);
    chk("first_partial", 32'(fault), 0);

    hold(3, 5);
    async_reset("rst_mid");

    gp = 1;
    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        hold(gp, pick_len(gp));
        gp = gp % 4 + 1;
      end else if (r < 77) begin
        cyc(3'($urandom), 3'($urandom));
      end else if (r < 84) begin
        gp = gp % 4 + 1;
      end else if (r < 90) begin
        cyc(R, R);
      end else if (r < 97) begin
        cyc(3'($urandom), 3'($urandom), 1'b1);
      end else begin
        async_reset("rst_rand");
      end
      if (m_state == 5 && $urandom_range(0, 2) == 0) begin
        hold(gp, $urandom_range(1, 10));
        cyc(lt_ns(gp), lt_ew(gp), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
